// File: rtl/ddr_lane_dly_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr_dly_pkg
// Shared encodings for the DDR3 PHY lane delay-line tap controller.
//   dly_op_e    : command opcodes carried on CMD_OP.
//   dly_state_e : sequencing states of the controller FSM.
// ---------------------------------------------------------------------------
package ddr_dly_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_INC   = 2'b01,
      OP_DEC   = 2'b10,
      OP_QUERY = 2'b11
   } dly_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MOVE,
      ST_SETTLE,
      ST_DONE
   } dly_state_e;

endpackage

// File: rtl/ddr_lane_dly_ctrl_if.sv
// ---------------------------------------------------------------------------
// ddr_lane_dly_ctrl_if
// Command/response bundle between the training FSM (master) and the lane
// delay controller (slave).
//   CMD_VALID/CMD_READY : command handshake, accepted when both high.
//   CMD_OP              : 00 LOAD, 01 INC, 10 DEC, 11 QUERY.
//   CMD_LANE_MASK       : lanes targeted by the command.
//   CMD_STEPS           : number of tap moves for INC/DEC.
//   RSP_VALID           : one-cycle completion pulse.
//   RSP_ERR             : some lane stopped early (held until next accept).
//   RSP_OOR_MASK        : lanes stopped early (held until next accept).
//   TAP_COUNT           : tracked tap per lane, lane i at [i*TAP_W +: TAP_W].
// ---------------------------------------------------------------------------
interface ddr_lane_dly_ctrl_if #(
   parameter int NUM_LANES = 2,
   parameter int TAP_W     = 8
);
   logic                       CMD_VALID;
   logic                       CMD_READY;
   logic [1:0]                 CMD_OP;
   logic [NUM_LANES-1:0]       CMD_LANE_MASK;
   logic [TAP_W-1:0]           CMD_STEPS;
   logic                       RSP_VALID;
   logic                       RSP_ERR;
   logic [NUM_LANES-1:0]       RSP_OOR_MASK;
   logic [NUM_LANES*TAP_W-1:0] TAP_COUNT;

   modport master (
      output CMD_VALID, CMD_OP, CMD_LANE_MASK, CMD_STEPS,
      input  CMD_READY, RSP_VALID, RSP_ERR, RSP_OOR_MASK, TAP_COUNT
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_LANE_MASK, CMD_STEPS,
      output CMD_READY, RSP_VALID, RSP_ERR, RSP_OOR_MASK, TAP_COUNT
   );
endinterface

// File: rtl/ddr_lane_dly_ctrl_lane_tap.sv
// ---------------------------------------------------------------------------
// ddr_dly_lane_tap
// Per-lane state of the delay controller: tap counter, selection/active
// flags, early-stop (OOR) flag and the registered LOAD/MOVE/DIRECTION
// outputs for one IOD delay line.
//   i_clk, i_rst   : clock, synchronous active-high reset.
//   i_accept       : command accepted this cycle; i_mask is this lane's bit.
//   i_inc          : current op is INC (selects which limit is checked).
//   i_check        : evaluate limit / OOR and drop the lane if needed.
//   i_load_go      : FSM enters LOAD next cycle.
//   i_move_go      : FSM enters MOVE next cycle.
//   i_dir_en       : DIRECTION must be driven next cycle.
//   i_oor          : IOD OUT_OF_RANGE flag for this lane.
//   o_tap          : tracked tap value.
//   o_keep         : lane survives the check performed this cycle.
//   o_oor/o_oor_nxt: registered OOR flag and its next value.
//   o_dir/o_load/o_move : registered IOD strobes.
// ---------------------------------------------------------------------------
module ddr_dly_lane_tap #(
   parameter int TAP_W    = 8,
   parameter int MAX_TAP  = 255,
   parameter int INIT_TAP = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_accept,
   input  logic             i_mask,
   input  logic             i_inc,
   input  logic             i_check,
   input  logic             i_load_go,
   input  logic             i_move_go,
   input  logic             i_dir_en,
   input  logic             i_oor,
   output logic [TAP_W-1:0] o_tap,
   output logic             o_keep,
   output logic             o_oor,
   output logic             o_oor_nxt,
   output logic             o_dir,
   output logic             o_load,
   output logic             o_move
);

   logic [TAP_W-1:0] r_tap;
   logic             r_sel;
   logic             r_active;
   logic             r_oor;
   logic             r_dir;
   logic             r_load;
   logic             r_move;

   logic             w_sel;
   logic             w_cand;
   logic             w_lim;
   logic             w_keep;
   logic             w_oor_nxt;

   // On the accept cycle the command's mask is not latched yet, so the
   // check works directly on the incoming mask bit.
   always_comb begin
      w_sel     = i_accept ? i_mask : r_sel;
      w_cand    = i_accept ? i_mask : r_active;
      w_lim     = i_inc ? (r_tap == TAP_W'(MAX_TAP)) : (r_tap == '0);
      w_keep    = w_cand & ~w_lim & ~i_oor;
      w_oor_nxt = (i_accept ? 1'b0 : r_oor) | (i_check & w_cand & ~w_keep);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tap    <= TAP_W'(INIT_TAP);
         r_sel    <= 1'b0;
         r_active <= 1'b0;
         r_oor    <= 1'b0;
         r_dir    <= 1'b0;
         r_load   <= 1'b0;
         r_move   <= 1'b0;
      end else begin
         r_sel  <= w_sel;
         if (i_check)
            r_active <= w_keep;
         r_oor  <= w_oor_nxt;
         r_dir  <= i_dir_en & w_sel;
         r_load <= i_load_go & w_sel;
         r_move <= i_move_go & w_keep;
         // Counter follows the pulse actually issued to the IOD; the
         // pre-check guarantees it never steps past 0 or MAX_TAP.
         if (r_load)
            r_tap <= TAP_W'(INIT_TAP);
         else if (r_move)
            r_tap <= r_dir ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));
      end
   end

   assign o_tap     = r_tap;
   assign o_keep    = w_keep;
   assign o_oor     = r_oor;
   assign o_oor_nxt = w_oor_nxt;
   assign o_dir     = r_dir;
   assign o_load    = r_load;
   assign o_move    = r_move;

endmodule

// File: rtl/ddr_lane_dly_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_lane_dly_ctrl
// Multi-lane IOD delay-line tap controller (FAB_CLK domain). Accepts
// LOAD/INC/DEC/QUERY commands, sequences LOAD/MOVE/DIRECTION pulses with a
// settle period after each pulse, tracks per-lane taps and stops lanes at
// range limits or on OUT_OF_RANGE.
//   FAB_CLK, SYNC_RST        : clock, synchronous active-high reset.
//   ctrl_bus (slave)         : command/response bundle.
//   DELAY_LINE_LOAD/MOVE     : one-cycle strobes per lane.
//   DELAY_LINE_DIRECTION     : 1 = increment, 0 = decrement.
//   DELAY_LINE_OUT_OF_RANGE  : IOD range flag, sampled in last settle cycle.
// ---------------------------------------------------------------------------
module ddr_lane_dly_ctrl
   import ddr_dly_pkg::*;
#(
   parameter int NUM_LANES  = 2,
   parameter int TAP_W      = 8,
   parameter int MAX_TAP    = 255,
   parameter int INIT_TAP   = 1,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 FAB_CLK,
   input  logic                 SYNC_RST,
   ddr_lane_dly_ctrl_if.slave   ctrl_bus,
   output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);

   dly_state_e                 r_state;
   dly_state_e                 w_next;
   dly_op_e                    r_op;
   dly_op_e                    w_op;
   logic [TAP_W-1:0]           r_steps;
   logic [TAP_W-1:0]           w_steps;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_ready;
   logic                       r_rsp_valid;
   logic                       r_rsp_err;

   logic                       w_accept;
   logic                       w_settle_end;
   logic                       w_check;
   logic                       w_load_go;
   logic                       w_move_go;
   logic                       w_dir_en;
   logic [NUM_LANES-1:0]       w_keep;
   logic [NUM_LANES-1:0]       w_oor;
   logic [NUM_LANES-1:0]       w_oor_nxt;
   logic [NUM_LANES*TAP_W-1:0] w_tap;

   assign w_accept     = r_ready & ctrl_bus.CMD_VALID;
   assign w_op         = w_accept ? dly_op_e'(ctrl_bus.CMD_OP) : r_op;
   assign w_steps      = w_accept ? ctrl_bus.CMD_STEPS : r_steps;
   assign w_settle_end = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(SETTLE_CYC - 1));
   // Lanes are only checked when another move is still owed, so a lane that
   // reaches its limit on the final step is not reported as stopped early.
   assign w_check      = (w_accept || w_settle_end) &&
                         (w_op == OP_INC || w_op == OP_DEC) && (w_steps != '0);

   // State register
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_op == OP_LOAD)
                  w_next = (|ctrl_bus.CMD_LANE_MASK) ? ST_LOAD : ST_DONE;
               else
                  w_next = (w_check && |w_keep) ? ST_MOVE : ST_DONE;
            end
         end
         ST_LOAD, ST_MOVE: w_next = ST_SETTLE;
         ST_SETTLE: begin
            if (w_settle_end)
               w_next = (w_check && |w_keep) ? ST_MOVE : ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Output logic: strobes are decided from the next state and registered
   // (here and in the lanes) so every output changes only on a clock edge.
   always_comb begin
      w_load_go = (w_next == ST_LOAD);
      w_move_go = (w_next == ST_MOVE);
      w_dir_en  = (w_op == OP_INC) && (w_next == ST_MOVE || w_next == ST_SETTLE);
   end

   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_ready     <= (w_next == ST_IDLE);
         r_rsp_valid <= (w_next == ST_DONE);
         if (w_next == ST_DONE)
            r_rsp_err <= |w_oor_nxt;
         else if (w_accept)
            r_rsp_err <= 1'b0;
         r_cnt <= (r_state == ST_SETTLE && !w_settle_end) ? (r_cnt + CNT_W'(1)) : '0;
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (w_accept) begin
         r_op    <= dly_op_e'(ctrl_bus.CMD_OP);
         r_steps <= ctrl_bus.CMD_STEPS;
      end else if (r_state == ST_MOVE) begin
         r_steps <= r_steps - TAP_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      ddr_dly_lane_tap #(
         .TAP_W    (TAP_W),
         .MAX_TAP  (MAX_TAP),
         .INIT_TAP (INIT_TAP)
      ) u_lane (
         .i_clk     (FAB_CLK),
         .i_rst     (SYNC_RST),
         .i_accept  (w_accept),
         .i_mask    (ctrl_bus.CMD_LANE_MASK[g]),
         .i_inc     (w_op == OP_INC),
         .i_check   (w_check),
         .i_load_go (w_load_go),
         .i_move_go (w_move_go),
         .i_dir_en  (w_dir_en),
         .i_oor     (DELAY_LINE_OUT_OF_RANGE[g]),
         .o_tap     (w_tap[g*TAP_W +: TAP_W]),
         .o_keep    (w_keep[g]),
         .o_oor     (w_oor[g]),
         .o_oor_nxt (w_oor_nxt[g]),
         .o_dir     (DELAY_LINE_DIRECTION[g]),
         .o_load    (DELAY_LINE_LOAD[g]),
         .o_move    (DELAY_LINE_MOVE[g])
      );
   end

   assign ctrl_bus.CMD_READY    = r_ready;
   assign ctrl_bus.RSP_VALID    = r_rsp_valid;
   assign ctrl_bus.RSP_ERR      = r_rsp_err;
   assign ctrl_bus.RSP_OOR_MASK = w_oor;
   assign ctrl_bus.TAP_COUNT    = w_tap;

endmodule

// File: tb/tb_ddr_lane_dly_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_lane_dly_ctrl
// Directed bench for ddr_lane_dly_ctrl with default parameters. Each command
// is issued at a known cycle c0; pulses, RSP_VALID and CMD_READY are logged
// per cycle c1..cN and compared against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_ddr_lane_dly_ctrl;
   import ddr_dly_pkg::*;

   localparam int NL = 2;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NL-1:0] dl_load, dl_move, dl_dir, dl_oor;

   ddr_lane_dly_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus_if ();

   ddr_lane_dly_ctrl dut (
      .FAB_CLK                 (clk),
      .SYNC_RST                (rst),
      .ctrl_bus                (bus_if),
      .DELAY_LINE_LOAD         (dl_load),
      .DELAY_LINE_MOVE         (dl_move),
      .DELAY_LINE_DIRECTION    (dl_dir),
      .DELAY_LINE_OUT_OF_RANGE (dl_oor)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [NL-1:0] mv_log  [0:31];
   logic [NL-1:0] ld_log  [0:31];
   logic [NL-1:0] dir_log [0:31];
   logic          rv_log  [0:31];
   logic          rd_log  [0:31];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NL-1:0] or_mv(input int a, input int b);
      logic [NL-1:0] acc = '0;
      for (int k = a; k <= b; k++) acc |= mv_log[k];
      return acc;
   endfunction

   function automatic logic [NL-1:0] or_ld(input int a, input int b);
      logic [NL-1:0] acc = '0;
      for (int k = a; k <= b; k++) acc |= ld_log[k];
      return acc;
   endfunction

   function automatic logic [NL-1:0] or_dir(input int a, input int b);
      logic [NL-1:0] acc = '0;
      for (int k = a; k <= b; k++) acc |= dir_log[k];
      return acc;
   endfunction

   function automatic int rv_count(input int a, input int b);
      int n = 0;
      for (int k = a; k <= b; k++) if (rv_log[k]) n++;
      return n;
   endfunction

   // Issue one command at c0, then log cycles c1..ncyc. OUT_OF_RANGE is
   // driven with oor_val during cycle oor_at; SYNC_RST is high during rst_at.
   task automatic issue(input logic [1:0] op, input logic [NL-1:0] mask, input logic [TW-1:0] steps,
                        input int ncyc, input int oor_at, input logic [NL-1:0] oor_val, input int rst_at);
      int guard = 0;
      @(negedge clk);
      while (!bus_if.CMD_READY && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_val("ready_before_cmd", bus_if.CMD_READY, 1);
      bus_if.CMD_VALID     = 1'b1;
      bus_if.CMD_OP        = op;
      bus_if.CMD_LANE_MASK = mask;
      bus_if.CMD_STEPS     = steps;
      @(posedge clk);
      #1;
      bus_if.CMD_VALID = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         dl_oor = (k == oor_at) ? oor_val : '0;
         rst    = (k == rst_at);
         @(negedge clk);
         mv_log[k]  = dl_move;
         ld_log[k]  = dl_load;
         dir_log[k] = dl_dir;
         rv_log[k]  = bus_if.RSP_VALID;
         rd_log[k]  = bus_if.CMD_READY;
         @(posedge clk);
         #1;
      end
      dl_oor = '0;
      rst    = 1'b0;
   endtask

   initial begin
      logic ok;
      rst                  = 1'b1;
      dl_oor               = '0;
      bus_if.CMD_VALID     = 1'b0;
      bus_if.CMD_OP        = 2'b00;
      bus_if.CMD_LANE_MASK = '0;
      bus_if.CMD_STEPS     = '0;

      // Reset held for three edges
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_tap",   bus_if.TAP_COUNT, 16'h0101);
      check_val("rst_ready", bus_if.CMD_READY, 0);
      check_val("rst_pulses", {dl_load, dl_move, dl_dir}, 0);
      check_val("rst_rsp",   {bus_if.RSP_VALID, bus_if.RSP_ERR, bus_if.RSP_OOR_MASK}, 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("ready_after_rst", bus_if.CMD_READY, 1);

      // INC 3 on both lanes
      issue(OP_INC, 2'b11, 8'd3, 17, 0, '0, 0);
      check_val("inc3_mv_c1",  mv_log[1], 2'b11);
      check_val("inc3_mv_c6",  mv_log[6], 2'b11);
      check_val("inc3_mv_c11", mv_log[11], 2'b11);
      check_val("inc3_mv_gap", or_mv(2, 5) | or_mv(7, 10) | or_mv(12, 17), 2'b00);
      ok = 1'b1;
      for (int k = 1; k <= 15; k++) if (dir_log[k] !== 2'b11) ok = 1'b0;
      check_val("inc3_dir_span", ok, 1);
      check_val("inc3_dir_done", dir_log[16], 2'b00);
      check_val("inc3_rv_c16", rv_log[16], 1);
      check_val("inc3_rv_cnt", rv_count(1, 17), 1);
      check_val("inc3_ready",  {rd_log[16], rd_log[17]}, 2'b01);
      check_val("inc3_no_ld",  or_ld(1, 17), 2'b00);
      check_val("inc3_tap",    bus_if.TAP_COUNT, 16'h0404);
      check_val("inc3_err",    bus_if.RSP_ERR, 0);

      // LOAD lane 1
      issue(OP_LOAD, 2'b10, 8'd0, 8, 0, '0, 0);
      check_val("load_ld_c1",  ld_log[1], 2'b10);
      check_val("load_ld_rest", or_ld(2, 8), 2'b00);
      check_val("load_no_mv",  or_mv(1, 8), 2'b00);
      check_val("load_rv_c6",  rv_log[6], 1);
      check_val("load_rv_cnt", rv_count(1, 8), 1);
      check_val("load_tap",    bus_if.TAP_COUNT, 16'h0104);

      // QUERY: immediate completion, no pulses
      issue(OP_QUERY, 2'b11, 8'd5, 3, 0, '0, 0);
      check_val("query_rv_c1",  rv_log[1], 1);
      check_val("query_pulses", {or_mv(1, 3), or_ld(1, 3), or_dir(1, 3)}, 0);
      check_val("query_tap",    bus_if.TAP_COUNT, 16'h0104);

      // INC 5 on lane 1, IOD flags out-of-range in cycle 10
      issue(OP_INC, 2'b10, 8'd5, 13, 10, 2'b10, 0);
      check_val("oor_mv_c1",  mv_log[1], 2'b10);
      check_val("oor_mv_c6",  mv_log[6], 2'b10);
      check_val("oor_mv_late", or_mv(7, 13), 2'b00);
      check_val("oor_rv_c11", {rv_log[10], rv_log[11]}, 2'b01);
      check_val("oor_err",    bus_if.RSP_ERR, 1);
      check_val("oor_mask",   bus_if.RSP_OOR_MASK, 2'b10);
      check_val("oor_tap",    bus_if.TAP_COUNT, 16'h0304);

      // LOAD lane 0 back to INIT_TAP, clears held error
      issue(OP_LOAD, 2'b01, 8'd0, 8, 0, '0, 0);
      check_val("load0_tap",  bus_if.TAP_COUNT, 16'h0301);
      check_val("load0_err",  {bus_if.RSP_ERR, bus_if.RSP_OOR_MASK}, 0);

      // DEC 2 on lane 0 from tap 1: stops at tap 0
      issue(OP_DEC, 2'b01, 8'd2, 8, 0, '0, 0);
      check_val("dec_mv_c1",  mv_log[1], 2'b01);
      check_val("dec_mv_rest", or_mv(2, 8), 2'b00);
      check_val("dec_dir",    or_dir(1, 8), 2'b00);
      check_val("dec_rv_c6",  rv_log[6], 1);
      check_val("dec_err",    bus_if.RSP_ERR, 1);
      check_val("dec_mask",   bus_if.RSP_OOR_MASK, 2'b01);
      check_val("dec_tap",    bus_if.TAP_COUNT, 16'h0300);

      // DEC with lane already at 0: dropped at accept, immediate DONE
      issue(OP_DEC, 2'b01, 8'd1, 4, 0, '0, 0);
      check_val("dec0_rv_c1", rv_log[1], 1);
      check_val("dec0_no_mv", or_mv(1, 4), 2'b00);
      check_val("dec0_err",   {bus_if.RSP_ERR, bus_if.RSP_OOR_MASK}, 3'b101);
      check_val("dec0_tap",   bus_if.TAP_COUNT, 16'h0300);

      // INC with zero steps: immediate DONE, no error
      issue(OP_INC, 2'b11, 8'd0, 4, 0, '0, 0);
      check_val("inc0_rv_c1",  rv_log[1], 1);
      check_val("inc0_pulses", {or_mv(1, 4), or_dir(1, 4)}, 0);
      check_val("inc0_err",    bus_if.RSP_ERR, 0);

      // INC 10 aborted by reset in cycle 8
      issue(OP_INC, 2'b11, 8'd10, 12, 0, '0, 8);
      check_val("abort_mv_c6",   mv_log[6], 2'b11);
      check_val("abort_mv_after", or_mv(9, 12) | or_dir(9, 12), 0);
      check_val("abort_no_rv",   rv_count(1, 12), 0);
      check_val("abort_ready",   {rd_log[9], rd_log[10]}, 2'b01);
      check_val("abort_tap",     bus_if.TAP_COUNT, 16'h0101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_lane_dly_ctrl.md
Name: ddr_lane_dly_ctrl

Overview:
- Multi-lane delay-line tap controller for the DDR3 PHY IOD lanes (DQ/DM/DQS).
- Accepts tap commands from training/calibration logic over a valid/ready handshake.
- Issues correctly sequenced DELAY_LINE_LOAD/MOVE/DIRECTION pulses to NUM_LANES IOD delay lines, tracks each lane's tap position, and stops per lane at range limits or on OUT_OF_RANGE.
- Sits between the training FSM and the per-lane IOD wrappers, in the FAB_CLK domain.

Parameters:
- NUM_LANES, 2, number of IOD delay lines controlled.
- TAP_W, 8, tap counter and step-count width.
- MAX_TAP, 255, highest legal tap value.
- INIT_TAP, 1, tap value after reset or LOAD; matches the IOD static delay value.
- SETTLE_CYC, 4, FAB_CLK cycles of settle after each LOAD/MOVE pulse (≥1).

Ports:
- FAB_CLK  in  1  sole clock.
- SYNC_RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  controller idle, command accepted when VALID&READY.
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 QUERY (no-op).
- CMD_LANE_MASK  in  NUM_LANES  lanes targeted.
- CMD_STEPS  in  TAP_W  number of tap moves for INC/DEC.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_ERR  out  1  any lane stopped early; valid with RSP_VALID, held until next accept.
- RSP_OOR_MASK  out  NUM_LANES  lanes stopped early; held until next accept.
- TAP_COUNT  out  NUM_LANES*TAP_W  tracked tap per lane, lane i at [i*TAP_W +: TAP_W].
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load pulse per lane.
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move pulse per lane.
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment, 0 = decrement.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD range flag, sampled in the last settle cycle.

Behaviour:
- Reset (SYNC_RST high at an edge):
  - state IDLE; all outputs 0 except TAP_COUNT = INIT_TAP per lane.
  - CMD_READY is 0 while SYNC_RST is high and 1 from the first cycle after release.
- Mid-operation reset: the command is aborted, no RSP_VALID is issued, and any pulse stops at the next edge.
- States: IDLE, LOAD, MOVE, SETTLE, DONE. All outputs are registered.
- IDLE:
  - CMD_READY=1. On accept (cycle c0), latch op, mask and steps; clear RSP_ERR/RSP_OOR_MASK; CMD_READY=0 from c1.
  - CMD_VALID while not ready is ignored.
- LOAD:
  - c1: DELAY_LINE_LOAD=mask, TAP_COUNT of masked lanes := INIT_TAP at c2.
  - Then SETTLE_CYC cycles, then DONE. RSP_VALID at c2+SETTLE_CYC.
- INC/DEC:
  - DIRECTION is driven for masked lanes from c1 until DONE; unmasked lanes hold 0.
  - Pre-check at accept and at the end of every SETTLE: drop any active lane at its limit (tap==MAX_TAP for INC, tap==0 for DEC) or with OUT_OF_RANGE=1, and set its RSP_OOR_MASK bit.
  - MOVE: one-cycle pulse on active lanes; those tap counters ±1 at the next edge; steps-1. Then SETTLE for SETTLE_CYC cycles.
  - After SETTLE: if steps==0 or the active mask is empty, go to DONE; else go to MOVE.
  - Full-run completion: RSP_VALID at c1 + N*(1+SETTLE_CYC).
- QUERY, CMD_STEPS==0, or an empty mask: no pulses, DONE at c1.
- DONE: RSP_VALID=1 for one cycle; RSP_ERR = |RSP_OOR_MASK; next state IDLE (CMD_READY=1 the following cycle).
- Pulse exclusivity: LOAD and MOVE are never asserted in the same cycle, and never on unmasked lanes.
- Tap arithmetic: counters never wrap; the saturation pre-check guarantees 0..MAX_TAP.

Decomposition:
- Package ddr_dly_pkg:
  - op encodings OP_LOAD/OP_INC/OP_DEC/OP_QUERY.
  - state enum.
- Sub-module ddr_dly_lane_tap:
  - one per lane, generated NUM_LANES times.
  - holds the tap counter, limit detection, active/OOR flag and the DIRECTION register.
  - takes load/move/dir strobes from the top-level FSM.

Test Plan:
Default parameters for all scenarios.
- Reset: hold SYNC_RST 3 cycles -> TAP_COUNT={1,1}, all pulses 0, CMD_READY 0 during reset and 1 the cycle after.
- INC, steps=3, mask=11 at c0 -> MOVE=11 at c1, c6, c11; DIRECTION=11 c1..c15; RSP_VALID c16; TAP={4,4}; RSP_ERR=0.
- DEC, steps=2, mask=01 from tap 1 -> MOVE[0] at c1 only; lane 0 dropped at tap 0; RSP_VALID c6; RSP_ERR=1; OOR_MASK=01; TAP={0,1}.
- INC, steps=5, mask=10; force OUT_OF_RANGE[1]=1 at c10 -> MOVE[1] at c1, c6 only; RSP_VALID c11; TAP1=3; RSP_ERR=1; OOR_MASK=10.
- From TAP={4,4}: LOAD, mask=10 -> LOAD=10 at c1 only; RSP_VALID c6; TAP={4,1}. Then QUERY -> RSP_VALID at c1 with no pulses.
- INC, steps=10, mask=11; SYNC_RST at c8 -> MOVE=0 from c9; no RSP_VALID; TAP={1,1}; CMD_READY=1 the first cycle after release.
